key_en_ctrl: RTL and testbench
==============================

KEY_EN_CTRL -- requirements
Module: key_en_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent key channels (1..16).
REQ-002 SHALL have parameter DB_CYC, default 16: debounce stability window in clocks (>=2).
REQ-003 SHALL have parameter LONG_CYC, default 1024: long-press threshold in clocks (>DB_CYC).
REQ-004 SHALL have parameter KEY_ACT_LOW, default 1: 1 = key_i pressed when 0; 0 = pressed when 1.
REQ-005 SHALL have port clk_i input 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port key_i input NUM_CH: raw asynchronous key levels, one bit per channel.
REQ-008 SHALL have port mode_i input 2*NUM_CH: per-channel mode, bits [2c+1:2c] for channel c.
REQ-009 SHALL have port clr_i input NUM_CH: synchronous per-channel enable clear.
REQ-010 SHALL have port en_o output NUM_CH: registered per-channel enable.
REQ-011 SHALL have port press_o output NUM_CH: one-cycle pulse per debounced press.
REQ-012 SHALL have port long_o output NUM_CH: one-cycle pulse per long press.

Function
REQ-013 Each key_i bit SHALL pass through a 2-flop synchroniser, then polarity normalisation per KEY_ACT_LOW.
REQ-014 Per-channel debounce FSM states: REL, PRESS_CHK, HELD, REL_CHK; counter width clog2(max(DB_CYC,LONG_CYC)).
REQ-015 REL: active sample -> PRESS_CHK, counter cleared.
REQ-016 PRESS_CHK: counter +1 per active sample; inactive sample -> REL; counter = DB_CYC-1 with active -> HELD.
REQ-017 HELD: inactive sample -> REL_CHK, counter cleared; REL_CHK: inactive +1, active -> HELD; counter = DB_CYC-1 with inactive -> REL.
REQ-018 Debounced level = 1 in HELD and REL_CHK, else 0.
REQ-019 press_o SHALL pulse high exactly one cycle on the PRESS_CHK->HELD transition; latency DB_CYC+3 rising edges after first edge sampling key_i active, key held stable.
REQ-020 Glitch shorter than DB_CYC consecutive samples SHALL produce no press_o, no en_o change.
REQ-021 Mode 00 toggle: en_o inverts in the cycle after press_o.
REQ-022 Mode 01 pulse: en_o equals press_o delayed one cycle.
REQ-023 Mode 10 level: en_o equals debounced level delayed one cycle.
REQ-024 Mode 11 latch: en_o set the cycle after press_o, held until clr_i.
REQ-025 clr_i SHALL force en_o to 0 next cycle in modes 00 and 11; clr_i and press same cycle: clear wins.
REQ-026 Mode change mid-operation SHALL not reset FSM/counter; en_o follows new mode rule from next cycle; toggle/latch start from current en_o value.
REQ-027 Channels SHALL be fully independent; simultaneous presses on all channels all honoured same cycle.

Reset
REQ-028 rst_ni low SHALL asynchronously force: synchronisers to inactive level, FSMs REL, counters 0, en_o 0, press_o 0, long_o 0.
REQ-029 Reset mid-press SHALL discard the press; a key still held after release of reset SHALL re-qualify from REL with full DB_CYC+3 latency.

Configuration
REQ-030 Macro KEY_EN_CTRL_LONGPRESS_EN defined: in HELD counter continues from DB_CYC-1, long_o pulses one cycle when counter reaches LONG_CYC-1, counter then saturates; one pulse per hold.
REQ-031 In long-press builds, mode 00 long press SHALL also clear en_o (same priority as clr_i).
REQ-032 Macro undefined: long_o tied 0, no long-press counting logic, mode 00 behaves per REQ-021 only.

Verification (NUM_CH=2, DB_CYC=4, LONG_CYC=16, KEY_ACT_LOW=1)
REQ-033 Reset then key_i[0] low held 10 cycles, mode 00 -> press_o[0] pulse at edge 7, en_o[0] 0->1 at edge 8; second press -> en_o[0] 1->0.
REQ-034 key_i[0] low 3 cycles then high -> press_o[0], en_o[0] remain 0.
REQ-035 Mode 11, press then clr_i[0] asserted coincident with later press_o -> en_o[0]=0 after clr.
REQ-036 Both channels pressed same cycle, ch0 mode 00, ch1 mode 10 -> both press_o pulse same cycle; en_o[1] follows debounced level, drops DB_CYC+4 edges after release.
REQ-037 rst_ni low at edge 5 of held press -> no press_o; after release of reset, held key yields press_o 7 edges later.
REQ-038 With KEY_EN_CTRL_LONGPRESS_EN, key held 40 cycles mode 00 -> press_o once, long_o once at counter 15, en_o returns 0; without macro long_o stays 0.

Source files
------------

// File: rtl/key_en_ctrl.sv
// key_en_ctrl: per-channel key debouncer with configurable enable behaviour.
// Each channel synchronises a raw key level, debounces it with a 4-state FSM
// and drives a registered enable according to a 2-bit mode (toggle, pulse,
// level, latch).
// Optional feature: define KEY_EN_CTRL_LONGPRESS_EN to add long-press
// detection (long_o pulse; a long press also clears en_o in toggle mode).
module key_en_ctrl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DB_CYC      = 16,
    parameter int unsigned LONG_CYC    = 1024,
    parameter bit          KEY_ACT_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_CH-1:0]     key_i,
    input  logic [2*NUM_CH-1:0]   mode_i,
    input  logic [NUM_CH-1:0]     clr_i,
    output logic [NUM_CH-1:0]     en_o,
    output logic [NUM_CH-1:0]     press_o,
    output logic [NUM_CH-1:0]     long_o
);

    localparam int unsigned CNT_MAX = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
    localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);
`ifdef KEY_EN_CTRL_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] LONG_PRE  = CW'(LONG_CYC - 2);
`endif

    typedef enum logic [1:0] {StRel, StPressChk, StHeld, StRelChk} state_e;

    logic [NUM_CH-1:0] sync1_q, sync2_q, act;

    // Two-flop synchroniser; resets to the idle (released) key level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= {NUM_CH{KEY_ACT_LOW}};
            sync2_q <= {NUM_CH{KEY_ACT_LOW}};
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so that 1 always means pressed.
    always_comb begin
        act = KEY_ACT_LOW ? ~sync2_q : sync2_q;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e          state_q;
        logic [CW-1:0]   cnt_q;
        logic            press_q;
        logic            long_q;
        logic            en_q;
        logic            deb;
        logic [1:0]      mode;

        assign mode = mode_i[2*c +: 2];
        assign deb  = (state_q == StHeld) || (state_q == StRelChk);

`ifdef KEY_EN_CTRL_LONGPRESS_EN
        // Remembers a long press already reported, so a release bounce that
        // returns to HELD cannot fire long_o a second time.
        logic long_done_q;
`else
        assign long_q = 1'b0;
`endif

        // Debounce FSM with registered press/long pulses.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StRel;
                cnt_q   <= '0;
                press_q <= 1'b0;
`ifdef KEY_EN_CTRL_LONGPRESS_EN
                long_q      <= 1'b0;
                long_done_q <= 1'b0;
`endif
            end else begin
                press_q <= 1'b0;
`ifdef KEY_EN_CTRL_LONGPRESS_EN
                long_q  <= 1'b0;
`endif
                unique case (state_q)
                    StRel: begin
                        if (act[c]) begin
                            state_q <= StPressChk;
                            cnt_q   <= '0;
                        end
                    end
                    StPressChk: begin
                        if (!act[c]) begin
                            state_q <= StRel;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= StHeld;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHeld: begin
                        if (!act[c]) begin
                            state_q <= StRelChk;
                            cnt_q   <= '0;
`ifdef KEY_EN_CTRL_LONGPRESS_EN
                        end else if (cnt_q != LONG_LAST && !long_done_q) begin
                            // Counter carries on from DB_CYC-1 and saturates.
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == LONG_PRE) begin
                                long_q      <= 1'b1;
                                long_done_q <= 1'b1;
                            end
`endif
                        end
                    end
                    StRelChk: begin
                        if (act[c]) begin
                            state_q <= StHeld;
`ifdef KEY_EN_CTRL_LONGPRESS_EN
                            cnt_q   <= DB_LAST;
`endif
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= StRel;
`ifdef KEY_EN_CTRL_LONGPRESS_EN
                            long_done_q <= 1'b0;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= StRel;
                endcase
            end
        end

        // Enable update per mode; clear (and long press) beats a press.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                en_q <= 1'b0;
            end else begin
                case (mode)
                    2'b00: begin
                        if (clr_i[c] || long_q) en_q <= 1'b0;
                        else if (press_q)       en_q <= ~en_q;
                    end
                    2'b01: en_q <= press_q;
                    2'b10: en_q <= deb;
                    default: begin
                        if (clr_i[c])     en_q <= 1'b0;
                        else if (press_q) en_q <= 1'b1;
                    end
                endcase
            end
        end

        assign en_o[c]    = en_q;
        assign press_o[c] = press_q;
        assign long_o[c]  = long_q;
    end

endmodule

// File: tb/tb_key_en_ctrl.sv
// Directed bench for key_en_ctrl (NUM_CH=2, DB_CYC=4, LONG_CYC=16, active-low keys).
// Expected long-press results follow KEY_EN_CTRL_LONGPRESS_EN when defined.
module tb_key_en_ctrl;

    logic       clk_i;
    logic       rst_ni;
    logic [1:0] key_i;
    logic [3:0] mode_i;
    logic [1:0] clr_i;
    logic [1:0] en_o;
    logic [1:0] press_o;
    logic [1:0] long_o;

    int n_checks = 0;
    int n_fail   = 0;

    key_en_ctrl #(
        .NUM_CH      (2),
        .DB_CYC      (4),
        .LONG_CYC    (16),
        .KEY_ACT_LOW (1'b1)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .key_i   (key_i),
        .mode_i  (mode_i),
        .clr_i   (clr_i),
        .en_o    (en_o),
        .press_o (press_o),
        .long_o  (long_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int n_press;
        int n_long;
        int long_at;
        logic [1:0] seen;

        rst_ni = 1'b0;
        key_i  = 2'b11;
        mode_i = 4'b0000;
        clr_i  = 2'b00;
        step(2);
        check_eq("rst_en", {30'd0, en_o}, 32'h0);
        check_eq("rst_press", {30'd0, press_o}, 32'h0);
        check_eq("rst_long", {30'd0, long_o}, 32'h0);
        rst_ni = 1'b1;
        step(3);

        // Toggle mode: first press sets en, second clears it.
        key_i = 2'b10;
        step(6);
        check_eq("tog_press_e6", {30'd0, press_o}, 32'h0);
        step(1);
        check_eq("tog_press_e7", {30'd0, press_o}, 32'h1);
        check_eq("tog_en_e7", {30'd0, en_o}, 32'h0);
        step(1);
        check_eq("tog_press_e8", {30'd0, press_o}, 32'h0);
        check_eq("tog_en_e8", {30'd0, en_o}, 32'h1);
        step(2);
        key_i = 2'b11;
        step(10);
        key_i = 2'b10;
        step(7);
        check_eq("tog2_press", {30'd0, press_o}, 32'h1);
        step(1);
        check_eq("tog2_en", {30'd0, en_o}, 32'h0);
        key_i = 2'b11;
        step(10);

        // Glitch of 3 samples must be rejected.
        seen  = 2'b00;
        key_i = 2'b10;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) key_i = 2'b11;
            step(1);
            seen = seen | press_o;
        end
        check_eq("glitch_press", {30'd0, seen}, 32'h0);
        check_eq("glitch_en", {30'd0, en_o}, 32'h0);

        // Latch mode with clear coincident with a later press.
        mode_i = 4'b0011;
        key_i  = 2'b10;
        step(7);
        check_eq("latch_press", {30'd0, press_o}, 32'h1);
        step(1);
        check_eq("latch_set", {30'd0, en_o}, 32'h1);
        key_i = 2'b11;
        step(10);
        check_eq("latch_hold", {30'd0, en_o}, 32'h1);
        key_i = 2'b10;
        step(7);
        check_eq("latch_press2", {30'd0, press_o}, 32'h1);
        clr_i = 2'b01;
        step(1);
        clr_i = 2'b00;
        check_eq("latch_clr", {30'd0, en_o}, 32'h0);
        step(1);
        check_eq("latch_clr_hold", {30'd0, en_o}, 32'h0);
        key_i = 2'b11;
        step(10);

        // Both channels together: ch0 toggle, ch1 level.
        mode_i = 4'b1000;
        key_i  = 2'b00;
        step(7);
        check_eq("dual_press", {30'd0, press_o}, 32'h3);
        check_eq("dual_en_e7", {30'd0, en_o}, 32'h0);
        step(1);
        check_eq("dual_en_e8", {30'd0, en_o}, 32'h3);
        step(3);
        key_i = 2'b11;
        step(7);
        check_eq("level_rel_e7", {30'd0, en_o}, 32'h3);
        step(1);
        check_eq("level_rel_e8", {30'd0, en_o}, 32'h1);
        step(10);

        // Mode change to pulse: en follows press_o delayed from next cycle.
        mode_i = 4'b1001;
        step(1);
        check_eq("modechg_en", {30'd0, en_o}, 32'h0);
        key_i = 2'b10;
        step(7);
        check_eq("pulse_press", {30'd0, press_o}, 32'h1);
        step(1);
        check_eq("pulse_en_hi", {30'd0, en_o}, 32'h1);
        step(1);
        check_eq("pulse_en_lo", {30'd0, en_o}, 32'h0);
        key_i = 2'b11;
        step(10);

        // Reset in the middle of a press discards it; held key re-qualifies.
        mode_i = 4'b0000;
        key_i  = 2'b10;
        step(4);
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_press", {30'd0, press_o}, 32'h0);
        check_eq("midrst_en", {30'd0, en_o}, 32'h0);
        step(2);
        rst_ni = 1'b1;
        step(6);
        check_eq("postrst_e6", {30'd0, press_o}, 32'h0);
        step(1);
        check_eq("postrst_e7", {30'd0, press_o}, 32'h1);
        step(1);
        check_eq("postrst_en", {30'd0, en_o}, 32'h1);
        key_i = 2'b11;
        step(10);

        // Clear in toggle mode, then a 40-cycle hold for long-press behaviour.
        clr_i = 2'b01;
        step(1);
        clr_i = 2'b00;
        check_eq("tog_clr", {30'd0, en_o}, 32'h0);
        n_press = 0;
        n_long  = 0;
        long_at = 0;
        seen    = 2'b00;
        key_i   = 2'b10;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (press_o[0]) n_press++;
            if (long_o[0]) begin
                n_long++;
                long_at = i;
            end
            seen = seen | long_o;
        end
        check_eq("hold_press_cnt", n_press, 1);
        check_eq("hold_long_ch1", {31'd0, seen[1]}, 32'h0);
`ifdef KEY_EN_CTRL_LONGPRESS_EN
        check_eq("hold_long_cnt", n_long, 1);
        check_eq("hold_long_at", long_at, 19);
        check_eq("hold_en", {30'd0, en_o}, 32'h0);
`else
        check_eq("hold_long_cnt", n_long, 0);
        check_eq("hold_en", {30'd0, en_o}, 32'h1);
`endif
        key_i = 2'b11;
        step(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
